mest_pro_mem_arbiter: RTL and testbench

//  Shares the single-port program/data memory (TOP_MESTProMem3) between the fetch unit (instruction read
//  by program counter) and the execute unit (data load/store). Serialises requests, drives select/CS/WE/addr,

---
 rtl/mest_pro_mem_pkg.sv | 19 +
 rtl/mest_pro_mem_prio.sv | 43 ++++
 rtl/mest_pro_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mest_pro_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mest_pro_mem_pkg.sv
// Shared types for the program/data memory arbiter.
// State and owner encodings plus memory select values.
package mest_pro_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  localparam logic MM_SEL_FETCH = 1'b0;
  localparam logic MM_SEL_DATA  = 1'b1;

endpackage

// File: rtl/mest_pro_mem_prio.sv
// Winner select between fetch and data requests.
// Data wins unless fetch has lost STARVE_MAX times in a row.
module mest_pro_mem_prio
  import mest_pro_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   f_req,
  input  logic   d_req,
  input  logic   take,
  output owner_t winner
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;
  logic          starved;

  assign starved = (cnt == CW'(STARVE_MAX));

  always_comb begin
    winner = OWN_FETCH;
    unique case (1'b1)
      d_req && !(f_req && starved): winner = OWN_DATA;
      default:                      winner = OWN_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (take) begin
      if (winner == OWN_FETCH) begin
        cnt <= '0;
      end else if (f_req && !starved) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mest_pro_mem_arbiter.sv
// Serialises fetch and data accesses onto one memory port.
// IDLE -> ISSUE -> RESP; all memory-side signals are registered.
module mest_pro_mem_arbiter
  import mest_pro_mem_pkg::*;
#(
  parameter int PC_BITS          = 16,
  parameter int ADDR_BITS        = 8,
  parameter int DATA_BITS        = 8,
  parameter int INSTRUCTION_SIZE = 16,
  parameter int STARVE_MAX       = 4
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic                        i_f_req,
  input  logic [PC_BITS-1:0]          i_f_pc,
  output logic                        o_f_gnt,
  output logic                        o_f_valid,
  output logic [INSTRUCTION_SIZE-1:0] o_f_inst,
  input  logic                        i_d_req,
  input  logic                        i_d_we,
  input  logic [ADDR_BITS-1:0]        i_d_addr,
  input  logic [DATA_BITS-1:0]        i_d_wdat,
  output logic                        o_d_gnt,
  output logic                        o_d_valid,
  output logic [DATA_BITS-1:0]        o_d_rdat,
  output logic                        o_mm_select,
  output logic [PC_BITS-1:0]          o_mm_pc,
  output logic [ADDR_BITS-1:0]        o_mm_addr,
  output logic [DATA_BITS-1:0]        o_mm_dat,
  output logic                        o_cs,
  output logic                        o_we,
  input  logic [INSTRUCTION_SIZE-1:0] i_inst,
  input  logic [DATA_BITS-1:0]        i_dat,
  input  logic                        i_error,
  output logic                        o_err
);

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t winner;
  logic   st_q, st_d;
  logic   take;

  logic                        f_gnt_d, f_valid_d;
  logic                        d_gnt_d, d_valid_d;
  logic [INSTRUCTION_SIZE-1:0] f_inst_d;
  logic [DATA_BITS-1:0]        d_rdat_d;
  logic                        sel_d;
  logic [PC_BITS-1:0]          pc_d;
  logic [ADDR_BITS-1:0]        addr_d;
  logic [DATA_BITS-1:0]        dat_d;
  logic                        cs_d, we_d, err_d;

  mest_pro_mem_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk   (clk),
    .rst_n (i_reset_n),
    .f_req (i_f_req),
    .d_req (i_d_req),
    .take  (take),
    .winner(winner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    st_d      = st_q;
    take      = 1'b0;
    f_gnt_d   = 1'b0;
    f_valid_d = 1'b0;
    d_gnt_d   = 1'b0;
    d_valid_d = 1'b0;
    cs_d      = 1'b0;
    we_d      = 1'b0;
    f_inst_d  = o_f_inst;
    d_rdat_d  = o_d_rdat;
    sel_d     = o_mm_select;
    pc_d      = o_mm_pc;
    addr_d    = o_mm_addr;
    dat_d     = o_mm_dat;
    err_d     = o_err;
    unique case (state_q)
      IDLE: begin
        if (i_f_req || i_d_req) begin
          take    = 1'b1;
          owner_d = winner;
          state_d = ISSUE;
          cs_d    = 1'b1;
          if (winner == OWN_DATA) begin
            d_gnt_d = 1'b1;
            sel_d   = MM_SEL_DATA;
            addr_d  = i_d_addr;
            dat_d   = i_d_wdat;
            we_d    = i_d_we;
            st_d    = i_d_we;
          end else begin
            f_gnt_d = 1'b1;
            sel_d   = MM_SEL_FETCH;
            pc_d    = i_f_pc;
          end
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        err_d   = o_err | i_error;
        if (owner_q == OWN_DATA) begin
          d_valid_d = 1'b1;
          if (!st_q) d_rdat_d = i_dat;
        end else begin
          f_valid_d = 1'b1;
          f_inst_d  = i_inst;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      st_q        <= 1'b0;
      o_f_gnt     <= 1'b0;
      o_f_valid   <= 1'b0;
      o_f_inst    <= '0;
      o_d_gnt     <= 1'b0;
      o_d_valid   <= 1'b0;
      o_d_rdat    <= '0;
      o_mm_select <= 1'b0;
      o_mm_pc     <= '0;
      o_mm_addr   <= '0;
      o_mm_dat    <= '0;
      o_cs        <= 1'b0;
      o_we        <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      st_q        <= st_d;
      o_f_gnt     <= f_gnt_d;
      o_f_valid   <= f_valid_d;
      o_f_inst    <= f_inst_d;
      o_d_gnt     <= d_gnt_d;
      o_d_valid   <= d_valid_d;
      o_d_rdat    <= d_rdat_d;
      o_mm_select <= sel_d;
      o_mm_pc     <= pc_d;
      o_mm_addr   <= addr_d;
      o_mm_dat    <= dat_d;
      o_cs        <= cs_d;
      o_we        <= we_d;
      o_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_mest_pro_mem_arbiter.sv
// Bench for mest_pro_mem_arbiter: memory emulator,
// transaction-level model and directed scenarios.
module tb_mest_pro_mem_arbiter;

  localparam int SMAX = 4;

  logic        clk;
  logic        i_reset_n;
  logic        i_f_req;
  logic [15:0] i_f_pc;
  logic        o_f_gnt, o_f_valid;
  logic [15:0] o_f_inst;
  logic        i_d_req, i_d_we;
  logic [7:0]  i_d_addr, i_d_wdat;
  logic        o_d_gnt, o_d_valid;
  logic [7:0]  o_d_rdat;
  logic        o_mm_select;
  logic [15:0] o_mm_pc;
  logic [7:0]  o_mm_addr, o_mm_dat;
  logic        o_cs, o_we;
  logic [15:0] i_inst;
  logic [7:0]  i_dat;
  logic        i_error;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  mest_pro_mem_arbiter #(
    .PC_BITS(16), .ADDR_BITS(8), .DATA_BITS(8),
    .INSTRUCTION_SIZE(16), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .i_reset_n(i_reset_n),
    .i_f_req(i_f_req), .i_f_pc(i_f_pc),
    .o_f_gnt(o_f_gnt), .o_f_valid(o_f_valid),
    .o_f_inst(o_f_inst),
    .i_d_req(i_d_req), .i_d_we(i_d_we),
    .i_d_addr(i_d_addr), .i_d_wdat(i_d_wdat),
    .o_d_gnt(o_d_gnt), .o_d_valid(o_d_valid),
    .o_d_rdat(o_d_rdat),
    .o_mm_select(o_mm_select), .o_mm_pc(o_mm_pc),
    .o_mm_addr(o_mm_addr), .o_mm_dat(o_mm_dat),
    .o_cs(o_cs), .o_we(o_we),
    .i_inst(i_inst), .i_dat(i_dat),
    .i_error(i_error), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] inst_of(input logic [15:0] pc);
    if (pc == 16'h0010) return 16'hA5C3;
    return {pc[7:0] ^ 8'h96, pc[15:8] ^ 8'h3C};
  endfunction

  // Memory emulator: synchronous read/write on chip select
  logic [7:0]  mem [256];
  logic [15:0] rd_inst;
  logic [7:0]  rd_dat;
  assign i_inst = rd_inst;
  assign i_dat  = rd_dat;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      if (o_cs) begin
        rd_inst <= inst_of(o_mm_pc);
        rd_dat  <= mem[o_mm_addr];
        if (o_we) mem[o_mm_addr] <= o_mm_dat;
      end
    end
  end

  // Transaction-level model: a transaction occupies three cycles
  logic [7:0]  mmem [256];
  logic        model_live = 1'b0;
  logic        e_f_gnt, e_f_valid, e_d_gnt, e_d_valid;
  logic        e_cs, e_we, e_sel, e_err;
  logic [15:0] e_inst, e_pc;
  logic [7:0]  e_rdat, e_addr, e_dat;

  initial begin
    int          busy;
    int          starve;
    logic        m_data, m_store, dwin;
    logic [7:0]  m_addr, m_wdat;
    logic [15:0] m_pc;
    for (int i = 0; i < 256; i++) mmem[i] = 8'(i) ^ 8'h5A;
    busy = 0; starve = 0;
    m_data = 0; m_store = 0; m_addr = 0; m_wdat = 0; m_pc = 0;
    forever begin
      @(posedge clk);
      model_live = 1'b1;
      e_f_gnt = 0; e_d_gnt = 0; e_f_valid = 0; e_d_valid = 0;
      e_cs = 0; e_we = 0;
      if (!i_reset_n) begin
        busy = 0; starve = 0;
        e_sel = 0; e_pc = 0; e_addr = 0; e_dat = 0;
        e_inst = 0; e_rdat = 0; e_err = 0;
      end else if (busy == 0) begin
        if (i_f_req || i_d_req) begin
          dwin = i_d_req && !(i_f_req && starve == SMAX);
          if (dwin) begin
            if (i_f_req && starve < SMAX) starve++;
            e_d_gnt = 1; e_sel = 1;
            e_addr = i_d_addr; e_dat = i_d_wdat; e_we = i_d_we;
            m_data = 1; m_store = i_d_we;
            m_addr = i_d_addr; m_wdat = i_d_wdat;
          end else begin
            starve = 0;
            e_f_gnt = 1; e_sel = 0; e_pc = i_f_pc;
            m_data = 0; m_pc = i_f_pc;
          end
          e_cs = 1;
          busy = 2;
        end
      end else if (busy == 2) begin
        busy = 1;
      end else begin
        busy = 0;
        if (i_error) e_err = 1;
        if (m_data) begin
          e_d_valid = 1;
          if (m_store) mmem[m_addr] = m_wdat;
          else e_rdat = mmem[m_addr];
        end else begin
          e_f_valid = 1;
          e_inst = inst_of(m_pc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("m_f_gnt", o_f_gnt, e_f_gnt);
      check("m_f_valid", o_f_valid, e_f_valid);
      check("m_f_inst", o_f_inst, e_inst);
      check("m_d_gnt", o_d_gnt, e_d_gnt);
      check("m_d_valid", o_d_valid, e_d_valid);
      check("m_d_rdat", o_d_rdat, e_rdat);
      check("m_sel", o_mm_select, e_sel);
      check("m_pc", o_mm_pc, e_pc);
      check("m_addr", o_mm_addr, e_addr);
      check("m_dat", o_mm_dat, e_dat);
      check("m_cs", o_cs, e_cs);
      check("m_we", o_we, e_we);
      check("m_err", o_err, e_err);
    end
  end

  task automatic fetch(input logic [15:0] pc, input logic err,
                       output int n);
    i_f_pc = pc; i_f_req = 1; n = 0;
    do begin @(negedge clk); n++; end while (!o_f_gnt && n < 20);
    check("f_gnt_seen", o_f_gnt, 1);
    check("f_gnt_sel", o_mm_select, 0);
    check("f_gnt_cs", o_cs, 1);
    i_f_req = 0;
    @(negedge clk);
    i_error = err;
    @(negedge clk);
    i_error = 0;
    check("f_valid_n3", o_f_valid, 1);
  endtask

  task automatic data(input logic we, input logic [7:0] a,
                      input logic [7:0] wd, output int n);
    i_d_we = we; i_d_addr = a; i_d_wdat = wd; i_d_req = 1; n = 0;
    do begin @(negedge clk); n++; end while (!o_d_gnt && n < 20);
    check("d_gnt_seen", o_d_gnt, 1);
    check("d_gnt_we", o_we, we);
    i_d_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("d_valid_n3", o_d_valid, 1);
  endtask

  initial begin
    int         n, grants, vcount;
    logic [9:0] ord, ord_exp;
    i_reset_n = 0; i_f_req = 1; i_d_req = 1;
    i_f_pc = 16'h0040; i_d_we = 0; i_d_addr = 0; i_d_wdat = 0;
    i_error = 0;
    repeat (3) @(negedge clk);
    check("rst_f_gnt", o_f_gnt, 0);
    check("rst_d_gnt", o_d_gnt, 0);
    check("rst_cs", o_cs, 0);
    i_reset_n = 1;
    @(negedge clk);
    check("rel_d_gnt", o_d_gnt, 1);
    check("rel_f_gnt", o_f_gnt, 0);
    i_f_req = 0; i_d_req = 0;
    repeat (2) @(negedge clk);
    check("rel_d_valid", o_d_valid, 1);
    check("rel_rdat", o_d_rdat, 8'h5A);

    fetch(16'h0010, 0, n);
    check("fetch_lat", n, 1);
    check("fetch_inst", o_f_inst, 16'hA5C3);

    data(1, 8'd8, 8'h3C, n);
    check("store_lat", n, 1);
    check("store_keep", o_d_rdat, 8'h5A);
    data(0, 8'd8, 8'h00, n);
    check("load_rdat", o_d_rdat, 8'h3C);

    fetch(16'h0020, 1, n);
    check("err_set", o_err, 1);
    repeat (4) @(negedge clk);
    check("err_sticky", o_err, 1);

    i_d_we = 0; i_d_addr = 8'd8; i_f_pc = 16'h0100;
    i_f_req = 1; i_d_req = 1;
    grants = 0; ord = '0; n = 0;
    while (grants < 10 && n < 60) begin
      @(negedge clk); n++;
      if (o_d_gnt) grants++;
      if (o_f_gnt) begin ord[grants] = 1'b1; grants++; end
    end
    i_f_req = 0; i_d_req = 0;
    ord_exp = 10'b10_0001_0000;
    check("starve_cnt", grants, 10);
    check("starve_order", ord, ord_exp);
    repeat (3) @(negedge clk);

    i_f_pc = 16'h0030; i_f_req = 1; n = 0;
    do begin @(negedge clk); n++; end while (!o_f_gnt && n < 20);
    check("mid_gnt", o_f_gnt, 1);
    i_f_req = 0;
    @(negedge clk);
    i_reset_n = 0;
    @(negedge clk);
    i_reset_n = 1;
    vcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_f_valid || o_d_valid) vcount++;
    end
    check("mid_no_valid", vcount, 0);
    check("mid_err_clr", o_err, 0);
    check("mid_cs", o_cs, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
